// File: rtl/data_types.sv
// Shared scalar types for the arbitrated queue slice.
package data_types;

  typedef logic [31:0] word32_t;

endpackage

// File: rtl/fifo.sv
// Circular queue with one spare slot; the popped word is registered on output.
module fifo
  import data_types::*;
#(
  parameter int WIDTH        = 32,
  parameter int ENTRIES_POW2 = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ENTRIES_POW2;

  typedef logic [ENTRIES_POW2-1:0] ptr_t;

  logic [WIDTH-1:0] mem_q [DEPTH];

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (wr_i) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (rd_i) begin
      rd_ptr_d  = rd_ptr_q + ptr_t'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (wr_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin arbitration of several writers into one shared queue,
// tagging each entry with the index of the requester that wrote it.
module fifo_arbiter
  import data_types::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ENTRIES_POW2 = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  word32_t [NUM_REQ-1:0]      req_data_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  input  logic                       read_i,
  output word32_t                    read_data_o,
  output logic [$clog2(NUM_REQ)-1:0] read_src_o,
  output logic [ENTRIES_POW2:0]      count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic [ENTRIES_POW2:0]   cnt_t;

  localparam cnt_t MAX_CNT = cnt_t'((1 << ENTRIES_POW2) - 1);

  idx_t    rr_ptr_q, rr_ptr_d;
  cnt_t    count_q, count_d;
  idx_t    gnt_idx;
  logic    gnt_vld;
  int      j;
  logic    wr_en;
  logic    rd_en;
  word32_t src_wr;
  word32_t src_rd;
  logic    unused_src_hi;

  assign full_o  = (count_q == MAX_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // First set request at or after rr_ptr, wrapping to 0.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_o   = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (!gnt_vld && req_i[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx_t'(j);
      end
    end
    if (full_o || reset_i) begin
      gnt_vld = 1'b0;
    end
    if (gnt_vld) begin
      gnt_o[gnt_idx] = 1'b1;
    end
  end

  assign wr_en  = gnt_vld;
  assign rd_en  = read_i && !empty_o && !reset_i;
  assign src_wr = 32'(gnt_idx);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      if (gnt_idx == idx_t'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + idx_t'(1);
      end
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo #(
    .WIDTH        (32),
    .ENTRIES_POW2 (ENTRIES_POW2)
  ) u_data_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_i      (wr_en),
    .wr_data_i (req_data_i[gnt_idx]),
    .rd_i      (rd_en),
    .rd_data_o (read_data_o)
  );

  fifo #(
    .WIDTH        (32),
    .ENTRIES_POW2 (ENTRIES_POW2)
  ) u_src_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_i      (wr_en),
    .wr_data_i (src_wr),
    .rd_i      (rd_en),
    .rd_data_o (src_rd)
  );

  assign read_src_o    = src_rd[IDX_W-1:0];
  assign unused_src_hi = |src_rd[31:IDX_W];

endmodule
